// File: rtl/stage_pkg.sv
// Stage encodings shared by the sequencer and its bench.
package stage_pkg;
  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    ST_IF    = 3'd0,
    ST_DEC   = 3'd1,
    ST_EX    = 3'd2,
    ST_MEM   = 3'd3,
    ST_FAULT = 3'd4
  } stage_t;
endpackage

// File: rtl/wait_timer.sv
// Saturating ack-wait counter; expired is high once the count reaches MAX_WAIT.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= 8'd0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIMIT);
endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle IF/[DEC]/EX/MEM stage controller with memory handshakes, bursts and ack timeout.
// Define STAGE_PERF_EN to add the instret and stall_cyc performance counters.
module stage_sequencer
  import stage_pkg::*;
#(
  parameter int DECODE_STAGE = 0,
  parameter int MAX_WAIT     = 15,
  parameter int BURST_W      = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               halt,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  input  logic               mem_inst,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               fault_clr,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               IR_Wen,
  output logic               EXtoMEM_Wen,
  output logic               PC_Wen,
  output logic               PSR_Wen,
  output logic               RF_Wen,
  output logic               ST_Wen,
  output logic [STAGE_W-1:0] stage,
  output logic               fault
`ifdef STAGE_PERF_EN
  ,
  output logic [31:0]        instret,
  output logic [31:0]        stall_cyc
`endif
);
  stage_t             state;
  stage_t             next_state;
  logic [BURST_W-1:0] beat_cnt;
  logic               wait_expired;
  logic               wait_clr;
  logic               wait_en;
  logic               last_beat;

  assign last_beat = (beat_cnt == BURST_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IF;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = ST_IF;
    case (state)
      ST_IF: begin
        if (halt)              next_state = ST_IF;
        else if (imem_ack)     next_state = (DECODE_STAGE != 0) ? ST_DEC : ST_EX;
        else if (wait_expired) next_state = ST_FAULT;
        else                   next_state = ST_IF;
      end
      ST_DEC:   next_state = ST_EX;
      ST_EX:    next_state = mem_inst ? ST_MEM : ST_IF;
      ST_MEM: begin
        if (dmem_ack)          next_state = last_beat ? ST_IF : ST_MEM;
        else if (wait_expired) next_state = ST_FAULT;
        else                   next_state = ST_MEM;
      end
      ST_FAULT: next_state = fault_clr ? ST_FAULT_EXIT() : ST_FAULT;
      default:  next_state = ST_IF;
    endcase
  end

  function automatic stage_t ST_FAULT_EXIT();
    return ST_IF;
  endfunction

  always_comb begin
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    IR_Wen      = 1'b0;
    EXtoMEM_Wen = 1'b0;
    PC_Wen      = 1'b0;
    PSR_Wen     = 1'b0;
    RF_Wen      = 1'b0;
    ST_Wen      = 1'b0;
    fault       = 1'b0;
    stage       = ST_IF;
    if (!reset) begin
      case (state)
        ST_IF: begin
          stage    = state;
          imem_req = !halt;
          IR_Wen   = !halt && imem_ack;
        end
        ST_DEC: stage = state;
        ST_EX: begin
          stage = state;
          if (mem_inst) begin
            EXtoMEM_Wen = 1'b1;
          end else begin
            PC_Wen  = 1'b1;
            PSR_Wen = 1'b1;
            RF_Wen  = 1'b1;
            ST_Wen  = 1'b1;
          end
        end
        ST_MEM: begin
          // PSR is deliberately untouched by loads/stores.
          stage    = state;
          dmem_req = 1'b1;
          RF_Wen   = dmem_ack;
          ST_Wen   = dmem_ack;
          PC_Wen   = dmem_ack && last_beat;
        end
        ST_FAULT: begin
          stage = state;
          fault = 1'b1;
        end
        default: stage = ST_IF;
      endcase
    end
  end

  // Counts only while a request is outstanding; a halted IF neither counts nor clears.
  assign wait_en  = imem_req || dmem_req;
  assign wait_clr = (next_state != state) || (imem_req && imem_ack) || (dmem_req && dmem_ack)
                  || !((state == ST_IF) || (state == ST_MEM));

  wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (wait_clr),
    .en     (wait_en),
    .expired(wait_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (state == ST_EX && mem_inst) begin
      beat_cnt <= (burst_len == '0) ? BURST_W'(1) : burst_len;
    end else if (state == ST_MEM && dmem_ack) begin
      beat_cnt <= beat_cnt - BURST_W'(1);
    end
  end

`ifdef STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      instret   <= 32'd0;
      stall_cyc <= 32'd0;
    end else begin
      if (PC_Wen) instret <= instret + 32'd1;
      if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) stall_cyc <= stall_cyc + 32'd1;
    end
  end
`endif
endmodule
